// File: rtl/logic_net_pkg.sv
// ============================================================================
// Module : logic_net_pkg
// Brief  : Shared types and helpers for the configurable LUT4 logic network.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package logic_net_pkg;

    localparam int LUT_K     = 4;
    localparam int TT_W      = 16;
    // Widest selector needed for the largest supported input vector (256 bits).
    localparam int SEL_MAX_W = 8;

    typedef struct packed {
        logic [LUT_K-1:0][SEL_MAX_W-1:0] sel;
        logic [TT_W-1:0]                 tt;
    } cfg_t;

    function automatic logic tt_is_const(input logic [TT_W-1:0] tt);
        return (tt == '0) || (tt == '1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut4_cell.sv
// ============================================================================
// Module : lut4_cell
// Brief  : Combinational 4-input lookup table cell.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lut4_cell
    import logic_net_pkg::*;
(
    input  logic [LUT_K-1:0] i_idx,
    input  logic [TT_W-1:0]  i_tt,
    output logic             o_y
);

    assign o_y = i_tt[i_idx];

endmodule

`default_nettype wire

// File: rtl/logic_net_pipe.sv
// ============================================================================
// Module : logic_net_pipe
// Brief  : Two-stage pipelined network of per-output LUT4 cells with runtime
//          selector/truth-table configuration and ready/valid handshakes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module logic_net_pipe
    import logic_net_pkg::*;
#(
    parameter  int IN_W  = 30,
    parameter  int OUT_W = 10,
    localparam int SEL_W = $clog2(IN_W),
    localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    output logic                 cfg_ready,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [4*SEL_W-1:0]   cfg_sel,
    input  logic [TT_W-1:0]      cfg_tt,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [OUT_W-1:0]     const_mask,
    output logic [15:0]          tx_count
);

    logic                     r_s1_valid;
    logic                     r_s2_valid;
    logic [LUT_K*OUT_W-1:0]   r_s1_bits;
    logic [OUT_W-1:0]         r_s2_data;
    logic [OUT_W-1:0]         r_const;
    logic [15:0]              r_tx;
    cfg_t                     r_cfg [OUT_W];

    logic                     w_en;
    logic                     w_cfg_acc;
    logic                     w_cfg_wr;
    logic                     w_in_fire;
    logic [255:0]             w_in_ext;
    logic [LUT_K*OUT_W-1:0]   w_gath;
    logic [OUT_W-1:0]         w_lut;

    assign w_en      = !(r_s2_valid && !out_ready);
    assign cfg_ready = !r_s1_valid && !r_s2_valid;
    assign w_cfg_acc = cfg_we && cfg_ready;
    assign w_cfg_wr  = w_cfg_acc && (32'(cfg_idx) < OUT_W);
    assign in_ready  = w_en && !w_cfg_acc;
    assign w_in_fire = in_valid && in_ready;

    // Zero padding makes any selector at or beyond IN_W read as 0.
    assign w_in_ext  = 256'(in_data);

    always_comb begin
        w_gath = '0;
        for (int i = 0; i < OUT_W; i++) begin
            for (int k = 0; k < LUT_K; k++) begin
                w_gath[i*LUT_K + k] = w_in_ext[r_cfg[i].sel[k]];
            end
        end
    end

    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_lut
        lut4_cell u_lut (
            .i_idx (r_s1_bits[gi*LUT_K +: LUT_K]),
            .i_tt  (r_cfg[gi].tt),
            .o_y   (w_lut[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_bits  <= '0;
            r_s2_data  <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_in_fire;
            r_s2_valid <= r_s1_valid;
            if (w_in_fire) begin
                r_s1_bits <= w_gath;
            end
            if (r_s1_valid) begin
                r_s2_data <= w_lut;
            end
        end
    end

    // Writes are only accepted with both stages empty, so no in-flight
    // vector ever sees a table that changed under it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_W; i++) begin
                r_cfg[i] <= '0;
            end
            r_const <= '1;
        end else if (w_cfg_wr) begin
            for (int i = 0; i < OUT_W; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    for (int k = 0; k < LUT_K; k++) begin
                        r_cfg[i].sel[k] <= SEL_MAX_W'(cfg_sel[k*SEL_W +: SEL_W]);
                    end
                    r_cfg[i].tt <= cfg_tt;
                    r_const[i]  <= tt_is_const(cfg_tt);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_tx <= r_tx + 16'd1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_data   = r_s2_data;
    assign const_mask = r_const;
    assign tx_count   = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_logic_net_pipe.sv
// ============================================================================
// Module : tb_logic_net_pipe
// Brief  : Self-checking bench for logic_net_pipe against a queue-based model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_logic_net_pipe;

    localparam int IN_W  = 30;
    localparam int OUT_W = 10;
    localparam int SEL_W = 5;
    localparam int IDX_W = 4;
    localparam int CS_W  = 4 * SEL_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic               cfg_ready;
    logic [IDX_W-1:0]   cfg_idx;
    logic [CS_W-1:0]    cfg_sel;
    logic [15:0]        cfg_tt;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [OUT_W-1:0]   const_mask;
    logic [15:0]        tx_count;

    logic_net_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_sel    (cfg_sel),
        .cfg_tt     (cfg_tt),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .const_mask (const_mask),
        .tx_count   (tx_count)
    );

    always #5 clk = ~clk;

    int                 n_cmp;
    int                 n_err;
    int                 n_out;
    int                 xfers;
    logic               last_in_f;
    int                 m_sel [OUT_W][4];
    logic [15:0]        m_tt  [OUT_W];
    logic [15:0]        m_tx;
    logic [OUT_W-1:0]   exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] model_eval(input logic [IN_W-1:0] d);
        logic [OUT_W-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < OUT_W; i++) begin
            idx = 0;
            for (int k = 0; k < 4; k++) begin
                if (m_sel[i][k] < IN_W && d[m_sel[i][k]]) idx += (1 << k);
            end
            r[i] = m_tt[i][idx];
        end
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] model_const();
        logic [OUT_W-1:0] c;
        for (int i = 0; i < OUT_W; i++) c[i] = (m_tt[i] == 16'h0000) || (m_tt[i] == 16'hFFFF);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < OUT_W; i++) begin
            m_tt[i] = 16'h0000;
            for (int k = 0; k < 4; k++) m_sel[i][k] = 0;
        end
        m_tx = 16'h0000;
        exp_q.delete();
    endtask

    // One clock: observe handshakes, advance the model, step, then check.
    task automatic tick();
        logic in_f, out_f, cfg_f, hold;
        logic [OUT_W-1:0] hold_val;
        #1;
        in_f  = in_valid && in_ready;
        out_f = out_valid && out_ready;
        cfg_f = cfg_we && (exp_q.size() == 0) && (int'(cfg_idx) < OUT_W);
        chk("cfg_ready", cfg_ready, exp_q.size() == 0);
        if (exp_q.size() == 0) chk("in_ready_empty", in_ready, !cfg_we);
        chk("valid_no_inflight", out_valid && (exp_q.size() == 0), 1'b0);
        hold     = out_valid && !out_ready;
        hold_val = out_data;
        if (out_f) begin
            if (exp_q.size() == 0) chk("spurious_out", 1'b1, 1'b0);
            else chk("out_data", out_data, exp_q.pop_front());
            m_tx = m_tx + 16'd1;
            n_out++;
            xfers++;
        end
        if (in_f) exp_q.push_back(model_eval(in_data));
        if (cfg_f) begin
            for (int k = 0; k < 4; k++) m_sel[cfg_idx][k] = int'(cfg_sel[k*SEL_W +: SEL_W]);
            m_tt[cfg_idx] = cfg_tt;
        end
        last_in_f = in_f;
        @(posedge clk);
        #1;
        if (hold) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, hold_val);
        end
        chk("tx_count", tx_count, m_tx);
        chk("const_mask", const_mask, model_const());
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic cfg_write(input int idx, input int s3, input int s2, input int s1,
                             input int s0, input logic [15:0] tt);
        cfg_we  = 1'b1;
        cfg_idx = IDX_W'(idx);
        cfg_sel = {SEL_W'(s3), SEL_W'(s2), SEL_W'(s1), SEL_W'(s0)};
        cfg_tt  = tt;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic send_get(input logic [IN_W-1:0] d, output logic [OUT_W-1:0] o);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        tick();
        in_valid  = 1'b0;
        tick();
        chk("send_valid", out_valid, 1'b1);
        o = out_data;
        tick();
    endtask

    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] cm_save;
    logic             pat [4];
    int               sent;
    int               n0;
    logic             seen0;

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_err = 0; n_out = 0; xfers = 0; last_in_f = 1'b0;
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_tt = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        do_reset();

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_const", const_mask, {OUT_W{1'b1}});
        chk("rst_tx", tx_count, 16'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cfg_ready", cfg_ready, 1'b1);

        // Latency and all-zero tables after reset
        out_ready = 1'b1;
        in_data   = IN_W'($urandom);
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        chk("lat1_valid", out_valid, 1'b0);
        tick();
        chk("lat2_valid", out_valid, 1'b1);
        chk("zero_out", out_data, '0);
        tick();
        chk("tx_one", tx_count, 16'd1);

        // AND4 on output 0
        cfg_write(0, 3, 2, 1, 0, 16'h8000);
        chk("and4_const", const_mask[0], 1'b0);
        send_get(30'h0000000F, o);
        chk("and4_hi", o[0], 1'b1);
        send_get(30'h00000007, o);
        chk("and4_lo", o[0], 1'b0);

        // Config write beats a simultaneous input on an empty pipeline
        in_valid = 1'b1;
        in_data  = IN_W'($urandom);
        cfg_we   = 1'b1;
        cfg_idx  = 4'd2;
        cfg_sel  = CS_W'($urandom);
        cfg_tt   = 16'h6996;
        #1;
        chk("cfg_wins", in_ready, 1'b0);
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Write attempted while a vector sits in S2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = IN_W'($urandom);
        tick();
        in_valid  = 1'b0;
        tick();
        cfg_we  = 1'b1;
        cfg_idx = 4'd0;
        cfg_sel = '0;
        cfg_tt  = 16'hFFFF;
        #1;
        chk("cfg_blocked", cfg_ready, 1'b0);
        tick();
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        send_get(30'h0000000F, o);
        chk("tt_unchanged", o[0], 1'b1);

        // Out-of-range index is ignored
        cm_save = const_mask;
        cfg_write(OUT_W, 0, 0, 0, 0, 16'h1234);
        chk("bad_idx_mask", const_mask, cm_save);

        // Selector beyond the input width reads 0
        cfg_write(1, 0, 0, 0, IN_W, 16'hAAAA);
        send_get({IN_W{1'b1}}, o);
        chk("sel_oob", o[1], 1'b0);
        cfg_write(1, 0, 0, 0, IN_W - 1, 16'hAAAA);
        send_get({IN_W{1'b1}}, o);
        chk("sel_top", o[1], 1'b1);

        // Eight vectors with out_ready cycling 1,0,0,1
        n0   = n_out;
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            out_ready = pat[c % 4];
            in_valid  = (sent < 8);
            in_data   = IN_W'($urandom);
            tick();
            if (last_in_f) sent++;
            if (sent >= 8 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0;
        chk("stream_sent", sent, 8);
        chk("stream_count", n_out - n0, 8);
        chk("stream_drained", exp_q.size(), 0);

        // Randomized traffic with interleaved config writes
        for (int c = 0; c < 500; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IN_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_idx   = IDX_W'($urandom_range(0, 11));
            cfg_sel   = CS_W'($urandom);
            case ($urandom_range(0, 3))
                0:       cfg_tt = 16'h0000;
                1:       cfg_tt = 16'hFFFF;
                default: cfg_tt = 16'($urandom);
            endcase
            tick();
        end
        cfg_we    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_drained", exp_q.size(), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = IN_W'($urandom);
        repeat (3) tick();
        in_valid = 1'b0;
        chk("full_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        do_reset();
        chk("rstmid_valid", out_valid, 1'b0);
        chk("rstmid_tx", tx_count, 16'd0);
        chk("rstmid_in_ready", in_ready, 1'b1);
        chk("rstmid_cfg_ready", cfg_ready, 1'b1);
        repeat (3) tick();

        // tx_count wrap
        xfers     = 0;
        seen0     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 66000 && xfers < 65537; c++) begin
            in_data = IN_W'($urandom);
            tick();
            if (xfers == 65536 && !seen0) begin
                chk("wrap_zero", tx_count, 16'd0);
                seen0 = 1'b1;
            end
        end
        chk("wrap_done", xfers, 65537);
        chk("wrap_one", tx_count, 16'd1);
        in_valid = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/logic_net_pipe.md
LOGIC_NET_PIPE -- requirements
Module: logic_net_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 30, meaning input vector width (2..256).
REQ-002 SHALL have parameter OUT_W, default 10, meaning output vector width (1..64).
REQ-003 SHALL derive localparams SEL_W = clog2(IN_W) and IDX_W = max(1, clog2(OUT_W)).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cfg_we  input  1  config write strobe.
REQ-008 cfg_ready  output  1  config write is accepted this cycle.
REQ-009 cfg_idx  input  IDX_W  target output bit.
REQ-010 cfg_sel  input  4*SEL_W  four input-bit selectors; selector k is in bits [k*SEL_W +: SEL_W].
REQ-011 cfg_tt  input  16  truth table; index = {b3,b2,b1,b0}.
REQ-012 in_valid / in_ready  input / output  1 each  input handshake.
REQ-013 in_data  input  IN_W  input vector.
REQ-014 out_valid / out_ready  output / input  1 each  output handshake.
REQ-015 out_data  output  OUT_W  evaluated vector.
REQ-016 const_mask  output  OUT_W  bit i=1: output i is input-independent.
REQ-017 tx_count  output  16  completed output transfers.

Function
REQ-018 Each output i SHALL equal cfg_tt_i indexed by {in_data[sel3], in_data[sel2], in_data[sel1], in_data[sel0]}, where sel0..sel3 are output i's stored selectors and bit b0 comes from sel0.
REQ-019 A selector value >= IN_W SHALL read as 0.
REQ-020 Pipeline SHALL have two stages: S1 registers the 4*OUT_W gathered bits; S2 registers the LUT result. Latency from an in handshake to out_valid SHALL be 2 cycles.
REQ-021 Both stages SHALL advance together when en = !(out_valid && !out_ready); in_ready = en && !(cfg_we && cfg_ready).
REQ-022 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 With out_ready held at 1, throughput SHALL be 1 vector per cycle.
REQ-024 cfg_ready SHALL be 1 only when S1 and S2 are both empty.
REQ-025 A write with cfg_we=1 and cfg_ready=0 SHALL be ignored.
REQ-026 A write with cfg_idx >= OUT_W SHALL be ignored.
REQ-027 An accepted write SHALL apply to vectors accepted on later cycles.
REQ-028 const_mask[i] SHALL be registered and equal 1 iff output i's stored table is 16'h0000 or 16'hFFFF; it updates the cycle after the write.
REQ-029 tx_count SHALL increment on each out_valid && out_ready and wrap from 16'hFFFF to 0.
REQ-030 cfg_we coincident with in_valid while the pipeline is empty: the config write SHALL win and in_ready SHALL be 0 that cycle.

Reset
REQ-031 On rst: all selectors = 0, all tables = 0, S1/S2 valid = 0, out_valid = 0, out_data = 0, const_mask = all ones, tx_count = 0.
REQ-032 rst asserted mid-operation SHALL discard in-flight vectors with no output transfer. in_ready and cfg_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-033 Shared package logic_net_pkg SHALL hold LUT_K=4, TT_W=16, the cfg record type {sel[4], tt} and a const-detect function.
REQ-034 A sub-module lut4_cell (4 select bits + 16-bit table -> 1 bit, combinational) SHALL be instantiated OUT_W times in S2.

Verification
REQ-035 Reset then in_data=any, out_ready=1 -> out_data=0 two cycles later; const_mask=all ones; tx_count=1.
REQ-036 Program out0: sel={3,2,1,0}, tt=16'h8000 (AND4); in_data=30'h0000000F -> out_data[0]=1; in_data=30'h00000007 -> out_data[0]=0; const_mask[0]=0.
REQ-037 Stream 8 vectors with out_ready toggling 1,0,0,1 -> all 8 outputs in order, none dropped or duplicated, out_data stable during stalls.
REQ-038 cfg_we while a vector is in S2 -> cfg_ready=0, table unchanged. Write to cfg_idx=OUT_W -> no change. Selector=IN_W -> that bit reads 0.
REQ-039 Preload tx_count to 16'hFFFE via 2 transfers after forced state, or run 65537 transfers -> count wraps to 0 then 1.
REQ-040 Assert rst with both stages full -> out_valid=0 the next cycle; no transfer counted.
